// File: rtl/alu_result_display.sv
// Signed 8-bit ALU result -> sign-magnitude BCD (sequential double dabble) -> 4-digit muxed 7-seg.
// Optional leading-zero blanking of hundreds/tens digits: define LEAD_ZERO_BLANK_EN.
module alu_result_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  y,
  output logic        busy,
  output logic [12:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int                REF_W   = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0]  REF_MAX = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        y_last_q, y_last_d;
  logic              neg_q, neg_d;
  logic [7:0]        mag_q, mag_d;
  logic [11:0]       acc_q, acc_d;
  logic [2:0]        iter_q, iter_d;
  logic [12:0]       bcd_q, bcd_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [11:0]       acc_adj;
  logic [19:0]       shifted;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [1:0] d, input logic [12:0] b);
    logic [6:0] s;
    case (d)
      2'd3:    s = b[12] ? 7'h40 : 7'h00;
`ifdef LEAD_ZERO_BLANK_EN
      2'd2:    s = (b[11:8] == 4'd0) ? 7'h00 : dec7(b[11:8]);
      2'd1:    s = (b[11:4] == 8'd0) ? 7'h00 : dec7(b[7:4]);
`else
      2'd2:    s = dec7(b[11:8]);
      2'd1:    s = dec7(b[7:4]);
`endif
      default: s = dec7(b[3:0]);
    endcase
    return s;
  endfunction

  // Conversion FSM and scan logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    y_last_d = y_last_q;
    neg_d    = neg_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    bcd_d    = bcd_q;

    acc_adj  = {dd_adj(acc_q[11:8]), dd_adj(acc_q[7:4]), dd_adj(acc_q[3:0])};
    shifted  = {acc_adj, mag_q} << 1;

    case (state_q)
      IDLE: begin
        if (y != y_last_q) begin
          y_last_d = y;
          neg_d    = y[7];
          mag_d    = y[7] ? (~y) + 8'd1 : y;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = shifted[19:8];
        mag_d  = shifted[7:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d   = {neg_q, acc_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ref_d   = (ref_q == REF_MAX) ? '0 : ref_q + 1'b1;
    digit_d = (ref_q == REF_MAX) ? digit_q + 2'd1 : digit_q;
    // Decode from next-state values so an/seg follow bcd in the same edge it updates.
    an_d    = 4'b0001 << digit_d;
    seg_d   = digit_seg(digit_d, bcd_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      y_last_q <= '0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      bcd_q    <= '0;
      ref_q    <= '0;
      digit_q  <= '0;
      an_q     <= 4'b0001;
      seg_q    <= 7'h3F;
    end else begin
      state_q  <= state_d;
      y_last_q <= y_last_d;
      neg_q    <= neg_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      bcd_q    <= bcd_d;
      ref_q    <= ref_d;
      digit_q  <= digit_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign bcd  = bcd_q;
  assign an   = SEG_ACTIVE_LOW ? ~an_q  : an_q;
  assign seg  = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with REFRESH_DIV=4, active-high outputs.
module tb_alu_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  y;
  logic        busy;
  logic [12:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_pass   = 0;

  alu_result_display #(
    .REFRESH_DIV   (4),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .y    (y),
    .busy (busy),
    .bcd  (bcd),
    .an   (an),
    .seg  (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    y   = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until busy falls (bounded); n = number of samples with busy high.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) n++;
      else break;
    end
  endtask

  task automatic capture_frame(output logic [6:0] s3, output logic [6:0] s2,
                               output logic [6:0] s1, output logic [6:0] s0);
    s3 = 'x; s2 = 'x; s1 = 'x; s0 = 'x;
    for (int i = 0; i < 16; i++) begin
      tick();
      case (an)
        4'b1000: s3 = seg;
        4'b0100: s2 = seg;
        4'b0010: s1 = seg;
        4'b0001: s0 = seg;
        default: ;
      endcase
    end
  endtask

  int         n, n2;
  logic [6:0] d3, d2, d1, d0;

  initial begin
    rst = 1'b0;
    y   = 8'h00;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd",  32'(bcd),  32'h0000);
    check("rst_an",   32'(an),   32'b0001);
    check("rst_seg",  32'(seg),  32'h3F);
    wait_idle(n);
    check("rst_no_conv", 32'(n), 32'd0);

    // -128
    y = 8'h80;
    wait_idle(n);
    check("m128_busy_cycles", 32'(n), 32'd9);
    check("m128_bcd", 32'(bcd), 32'h1128);
    capture_frame(d3, d2, d1, d0);
    check("m128_d3", 32'(d3), 32'h40);
    check("m128_d2", 32'(d2), 32'h06);
    check("m128_d1", 32'(d1), 32'h5B);
    check("m128_d0", 32'(d0), 32'h7F);

    // +7
    y = 8'h07;
    wait_idle(n);
    check("p7_busy_cycles", 32'(n), 32'd9);
    check("p7_bcd", 32'(bcd), 32'h0007);
    capture_frame(d3, d2, d1, d0);
    check("p7_d3", 32'(d3), 32'h00);
`ifdef LEAD_ZERO_BLANK_EN
    check("p7_d2", 32'(d2), 32'h00);
    check("p7_d1", 32'(d1), 32'h00);
`else
    check("p7_d2", 32'(d2), 32'h3F);
    check("p7_d1", 32'(d1), 32'h3F);
`endif
    check("p7_d0", 32'(d0), 32'h07);

    // 100 then -5 while converting
    y = 8'd100;
    tick();
    tick();
    tick();
    check("chg_busy_mid", 32'(busy), 32'd1);
    y = 8'hFB;
    wait_idle(n2);
    check("chg_first_len", 32'(3 + n2), 32'd9);
    check("chg_first_bcd", 32'(bcd), 32'h0100);
    tick();
    check("chg_busy_again", 32'(busy), 32'd1);
    check("chg_hold_bcd", 32'(bcd), 32'h0100);
    wait_idle(n2);
    check("chg_second_len", 32'(1 + n2), 32'd9);
    check("chg_second_bcd", 32'(bcd), 32'h1005);

    // Reset mid-conversion
    do_reset();
    y = 8'd127;
    tick();
    tick();
    tick();
    tick();
    check("mrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_bcd",  32'(bcd),  32'h0000);
    wait_idle(n);
    check("mrst_busy_cycles", 32'(n), 32'd9);
    check("mrst_bcd_after", 32'(bcd), 32'h0127);

    // Scan wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [3:0] exp_an;
      exp_an = 4'b0001 << ((i / 4) % 4);
      check($sformatf("scan_an_%0d", i), 32'(an), 32'(exp_an));
      tick();
    end
    check("scan_no_conv", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
